call_return_unit: RTL and testbench

Sequencer sitting directly upstream of the 16-entry, 10-bit return-address stack in the 8-bit CPU. Accepts decoded CALL/RET (and optionally interrupt entry/exit) requests from the control unit, drives the stack's enable/operation/data_in port, captures popped addresses, and issues a single-cycle program-counter load. Detects stack overflow/underflow before touching the stack and halts in a sticky fault state.

---
 rtl/cru_pkg.sv | 19 +
 rtl/call_return_unit.sv | 169 ++++++++++++++++
 tb/tb_call_return_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cru_pkg.sv
// Shared types and constants for the CALL/RET sequencer in front of the return-address stack.
package cru_pkg;

  localparam int CRU_PC_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_POP_WAIT,
    ST_LOAD,
    ST_FAULT
  } cru_state_t;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UNF  = 2'b10;

endpackage

// File: rtl/call_return_unit.sv
// CALL/RET sequencer driving the return-address stack; CALL loads PC 2 cycles after accept, RET 3.
// Requests are only sampled while busy=0 and are dropped otherwise; CALLRET_IRQ_EN adds interrupt entry/exit.
module call_return_unit
  import cru_pkg::*;
#(
  parameter int                  PC_WIDTH   = CRU_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = PC_WIDTH'(4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                call_req,
  input  logic                ret_req,
  input  logic [PC_WIDTH-1:0] call_target,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                irq_req,
  input  logic                reti_req,
  output logic                busy,
  output logic                done,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_load_value,
  output logic                irq_ack,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic                stk_enable,
  output logic                stk_operation,
  output logic [PC_WIDTH-1:0] stk_data,
  input  logic [PC_WIDTH-1:0] stk_q,
  input  logic                stk_full,
  input  logic                stk_empty
);

  cru_state_t          state;
  logic                take_irq;
  logic                take_reti;
  logic                take_call;
  logic                take_ret;
  logic [PC_WIDTH-1:0] call_dest;

`ifdef CALLRET_IRQ_EN
  logic in_isr;
  logic op_irq;
  logic op_reti;

  // No nesting: a pending interrupt waits until the handler has returned.
  assign take_irq  = irq_req & ~in_isr;
  assign take_reti = reti_req;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = irq_req ^ reti_req;
  assign take_irq          = 1'b0;
  assign take_reti         = 1'b0;
`endif

  assign take_call = take_irq | call_req;
  assign take_ret  = ~take_call & (take_reti | ret_req);
  assign call_dest = take_irq ? IRQ_VECTOR : call_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_value <= '0;
      fault         <= 1'b0;
      fault_code    <= FLT_NONE;
      stk_enable    <= 1'b0;
      stk_operation <= 1'b0;
      stk_data      <= '0;
    end else begin
      done          <= 1'b0;
      pc_load       <= 1'b0;
      stk_enable    <= 1'b0;
      stk_operation <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // full/empty are trustworthy here: nothing else moves the stack pointer.
          if (take_call) begin
            busy <= 1'b1;
            if (stk_full) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FLT_OVF;
              done       <= 1'b1;
            end else begin
              state         <= ST_PUSH;
              stk_enable    <= 1'b1;
              stk_operation <= 1'b1;
              stk_data      <= pc_in;
              pc_load_value <= call_dest;
            end
          end else if (take_ret) begin
            busy <= 1'b1;
            if (stk_empty) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= FLT_UNF;
              done       <= 1'b1;
            end else begin
              state      <= ST_POP;
              stk_enable <= 1'b1;
            end
          end
        end
        ST_PUSH: begin
          state   <= ST_LOAD;
          pc_load <= 1'b1;
          done    <= 1'b1;
        end
        ST_POP: begin
          state <= ST_POP_WAIT;
        end
        ST_POP_WAIT: begin
          state         <= ST_LOAD;
          pc_load_value <= stk_q;
          pc_load       <= 1'b1;
          done          <= 1'b1;
        end
        ST_LOAD: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CALLRET_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_isr  <= 1'b0;
      op_irq  <= 1'b0;
      op_reti <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          op_irq  <= take_irq;
          op_reti <= take_ret & take_reti;
          if (take_irq && !stk_full) begin
            in_isr <= 1'b1;
          end
        end
        ST_PUSH: begin
          irq_ack <= op_irq;
        end
        ST_POP_WAIT: begin
          if (op_reti) begin
            in_isr <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  assign irq_ack = 1'b0;
`endif

endmodule

// File: tb/tb_call_return_unit.sv
// Scoreboard bench for call_return_unit with a behavioural 16-entry stack beside it.
module tb_call_return_unit;
  import cru_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       call_req = 1'b0, ret_req = 1'b0, irq_req = 1'b0, reti_req = 1'b0;
  logic [9:0] call_target = '0, pc_in = '0;
  logic       busy, done, pc_load, irq_ack, fault, stk_enable, stk_operation;
  logic [9:0] pc_load_value, stk_data, stk_q;
  logic [1:0] fault_code;
  logic       stk_full, stk_empty;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    bit         en;
    bit         op;
    logic [9:0] sd;
    bit         dn;
    bit         pl;
    logic [9:0] plv;
    bit         ack;
    bit         flt;
    logic [1:0] fc;
  } ev_t;
  ev_t exp_q[$];

  call_return_unit dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req),
    .call_target(call_target), .pc_in(pc_in), .irq_req(irq_req), .reti_req(reti_req),
    .busy(busy), .done(done), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .irq_ack(irq_ack), .fault(fault), .fault_code(fault_code),
    .stk_enable(stk_enable), .stk_operation(stk_operation), .stk_data(stk_data),
    .stk_q(stk_q), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stack model: full at 15 entries, q registered and valid the cycle after a pop.
  logic [9:0] smem [16];
  int scnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt  <= 0;
      stk_q <= '0;
    end else if (stk_enable) begin
      if (stk_operation && scnt < 16) begin
        smem[scnt] <= stk_data;
        scnt       <= scnt + 1;
      end else if (!stk_operation && scnt > 0) begin
        stk_q <= smem[scnt-1];
        scnt  <= scnt - 1;
      end
    end
  end
  assign stk_full  = (scnt >= 15);
  assign stk_empty = (scnt == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input bit en, op, input logic [9:0] sd,
                         input bit dn, pl, input logic [9:0] plv,
                         input bit ack, flt, input logic [1:0] fc);
    ev_t e;
    e.cyc = c; e.en = en; e.op = op; e.sd = sd; e.dn = dn;
    e.pl = pl; e.plv = plv; e.ack = ack; e.flt = flt; e.fc = fc;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with a visible output pulse must match the next expected event.
  always @(negedge clk) begin
    if (stk_enable || done || pc_load || irq_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event cyc=%0d en=%b op=%b done=%b pl=%b plv=%0h ack=%b fault=%b code=%0d",
                 cyc, stk_enable, stk_operation, done, pc_load, pc_load_value, irq_ack, fault, fault_code);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_stk_enable", {31'd0, stk_enable}, {31'd0, e.en});
        chk("ev_stk_operation", {31'd0, stk_operation}, {31'd0, e.op});
        if (e.en && e.op) chk("ev_stk_data", {22'd0, stk_data}, {22'd0, e.sd});
        chk("ev_done", {31'd0, done}, {31'd0, e.dn});
        chk("ev_pc_load", {31'd0, pc_load}, {31'd0, e.pl});
        if (e.pl) chk("ev_pc_load_value", {22'd0, pc_load_value}, {22'd0, e.plv});
        chk("ev_irq_ack", {31'd0, irq_ack}, {31'd0, e.ack});
        chk("ev_fault", {31'd0, fault}, {31'd0, e.flt});
        chk("ev_fault_code", {30'd0, fault_code}, {30'd0, e.fc});
      end
    end
  end

  task automatic drained(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_reqs();
    call_req = 0; ret_req = 0; irq_req = 0; reti_req = 0;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_call(input logic [9:0] pc, tgt, input bit flt, via_irq, with_ret);
    int a;
    logic [9:0] dest;
    a = cyc + 1;
    dest = via_irq ? 10'h004 : tgt;
    if (via_irq) irq_req = 1; else call_req = 1;
    ret_req = with_ret; pc_in = pc; call_target = tgt;
    if (flt) begin
      push_ev(a, 0, 0, 10'h0, 1, 0, 10'h0, 0, 1, FLT_OVF);
    end else begin
      push_ev(a,     1, 1, pc,    0, 0, 10'h0, 0,       0, FLT_NONE);
      push_ev(a + 1, 0, 0, 10'h0, 1, 1, dest,  via_irq, 0, FLT_NONE);
    end
    @(negedge clk);
    clear_reqs();
    repeat (2) @(negedge clk);
    drained("call_events_drained");
    chk("call_busy_after", {31'd0, busy}, {31'd0, flt});
  endtask

  task automatic do_ret(input logic [9:0] exp_addr, input bit flt, use_reti);
    int a;
    a = cyc + 1;
    if (use_reti) reti_req = 1; else ret_req = 1;
    if (flt) begin
      push_ev(a, 0, 0, 10'h0, 1, 0, 10'h0, 0, 1, FLT_UNF);
    end else begin
      push_ev(a,     1, 0, 10'h0, 0, 0, 10'h0,    0, 0, FLT_NONE);
      push_ev(a + 2, 0, 0, 10'h0, 1, 1, exp_addr, 0, 0, FLT_NONE);
    end
    @(negedge clk);
    clear_reqs();
    repeat (flt ? 2 : 3) @(negedge clk);
    drained("ret_events_drained");
    chk("ret_busy_after", {31'd0, busy}, {31'd0, flt});
  endtask

  // Requests that must produce no activity at all.
  task automatic ignored(input bit c, r, i, ri, input bit exp_busy);
    call_req = c; ret_req = r; irq_req = i; reti_req = ri;
    pc_in = 10'h3AA; call_target = 10'h155;
    repeat (3) @(negedge clk);
    clear_reqs();
    repeat (2) @(negedge clk);
    drained("ignored_no_events");
    chk("ignored_busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  function automatic logic [31:0] out_vec();
    return {busy, done, pc_load, irq_ack, fault, fault_code, stk_enable, stk_operation,
            1'b0, pc_load_value, stk_data};
  endfunction

  task automatic do_reset();
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk("reset_outputs_zero", out_vec(), 32'd0);
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_fault", {31'd0, fault}, 0);
    chk("reset_all_outputs", out_vec(), 32'd0);
    rst = 0;
    repeat (2) @(negedge clk);

    do_call(10'h011, 10'h080, 0, 0, 0);
    do_ret(10'h011, 0, 0);
    chk("stack_empty_after_ret", {31'd0, stk_empty}, 1);

    // Simultaneous call and ret: call wins, ret is dropped.
    do_call(10'h123, 10'h0A5, 0, 0, 1);
    chk("stack_depth_after_dual", scnt, 1);
    do_ret(10'h123, 0, 0);

`ifdef CALLRET_IRQ_EN
    do_call(10'h020, 10'h3FF, 0, 1, 0);
    ignored(0, 0, 1, 0, 0);
    do_ret(10'h020, 0, 1);
    chk("stack_empty_after_reti", {31'd0, stk_empty}, 1);
`else
    ignored(0, 0, 1, 1, 0);
`endif

    for (int i = 0; i < 15; i++) begin
      do_call(10'h040 + 10'(i), 10'h100 + 10'(i), 0, 0, 0);
    end
    chk("stack_full_at_15", {31'd0, stk_full}, 1);
    do_call(10'h0FF, 10'h2FF, 1, 0, 0);
    chk("overflow_fault", {31'd0, fault}, 1);
    chk("overflow_code", {30'd0, fault_code}, {30'd0, FLT_OVF});
    ignored(1, 1, 0, 0, 1);
    chk("fault_sticky", {30'd0, fault_code}, {30'd0, FLT_OVF});

    do_reset();
    do_ret(10'h0, 1, 0);
    chk("underflow_fault", {31'd0, fault}, 1);
    chk("underflow_code", {30'd0, fault_code}, {30'd0, FLT_UNF});

    do_reset();
    chk("fault_cleared", {31'd0, fault}, 0);
    do_call(10'h200, 10'h300, 0, 0, 0);

    // Reset while the pop result is in flight: the pending load must vanish.
    a = cyc + 1;
    ret_req = 1;
    push_ev(a, 1, 0, 10'h0, 0, 0, 10'h0, 0, 0, FLT_NONE);
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    rst = 1;
    exp_q.delete();
    #1;
    chk("rst_popwait_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("rst_popwait_outputs", out_vec(), 32'd0);
    rst = 0;
    repeat (4) @(negedge clk);
    drained("rst_popwait_no_load");

    do_call(10'h015, 10'h0C0, 0, 0, 0);
    do_ret(10'h015, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
